// File: rtl/uart_echo_buffer.sv
// -----------------------------------------------------------------------------
// uart_echo_buffer
//   Buffers bytes from a UART receiver in a circular FIFO and replays them to
//   the UART transmitter over a send/busy handshake, so the link echoes what
//   it receives. Draining can be held off with a level enable (typically a
//   debounced push-button) to release the buffered bytes in bursts.
//
// Optional feature (compile-time macro ECHO_UPPERCASE_EN):
//   When defined, lowercase ASCII 'a'..'z' is stored as 'A'..'Z' on the write
//   path, with no added latency. When undefined, bytes are stored verbatim.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   DATA_W       byte width
//   BUSY_TIMEOUT max cycles to wait for i_tx_busy to rise after a send pulse
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_rx_data_valid  one-cycle strobe, i_rx_data valid this cycle
//   i_rx_data        received byte
//   i_drain_en       level, 1 = FIFO may be drained to the transmitter
//   i_tx_busy        high while the transmitter shifts a frame
//   o_tx_send        one-cycle transmit request pulse
//   o_tx_data        byte presented to the transmitter (registered)
//   o_fifo_count     occupancy 0..DEPTH
//   o_fifo_empty     occupancy == 0
//   o_fifo_full      occupancy == DEPTH
//   o_overflow       sticky, set when a byte is dropped
// -----------------------------------------------------------------------------
module uart_echo_buffer #(
    parameter int DEPTH        = 16,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 15,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH) + 1,
    localparam int TO_W        = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_data_valid,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_drain_en,
    input  logic              i_tx_busy,
    output logic              o_tx_send,
    output logic [DATA_W-1:0] o_tx_data,
    output logic [CNT_W-1:0]  o_fifo_count,
    output logic              o_fifo_empty,
    output logic              o_fifo_full,
    output logic              o_overflow
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_SEND       = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

    // Write-path byte transform; identity unless the uppercase echo is built in.
    function automatic logic [DATA_W-1:0] f_store_byte(input logic [DATA_W-1:0] d);
`ifdef ECHO_UPPERCASE_EN
        if ((d >= DATA_W'(8'h61)) && (d <= DATA_W'(8'h7A))) begin
            return d - DATA_W'(8'h20);
        end else begin
            return d;
        end
`else
        return d;
`endif
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_tx_send;
    logic [DATA_W-1:0] r_tx_data;
    logic [TO_W-1:0]   r_to_cnt;
    state_t            r_state;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [TO_W-1:0]   w_to_nxt;
    state_t            w_state_nxt;

    // A pop frees a slot in the same cycle, so a push at full is still accepted then.
    assign w_pop  = (r_state == S_LOAD);
    assign w_push = i_rx_data_valid && (!r_full || w_pop);
    assign w_drop = i_rx_data_valid && r_full && !w_pop;

    // Next occupancy from the push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage write port; contents need no reset since pointers gate reads.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_mem[r_wr_ptr] <= f_store_byte(i_rx_data);
        end
    end

    // FIFO pointers, occupancy, flags and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == {CNT_W{1'b0}});
            r_full  <= (w_count_nxt == CNT_FULL);
        end
    end

    // TX handshake next-state and timeout counter.
    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to_cnt;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && i_drain_en && !i_tx_busy) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_to_nxt    = {TO_W{1'b0}};
                w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                // A transmitter that never acknowledges must not hang the echo.
                if (i_tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt    = r_to_cnt + TO_W'(1);
                    w_state_nxt = S_WAIT_START;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_to_nxt    = {TO_W{1'b0}};
            end
        endcase
    end

    // TX state register plus registered send pulse and data byte.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_to_cnt  <= {TO_W{1'b0}};
            r_tx_send <= 1'b0;
            r_tx_data <= {DATA_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_to_cnt  <= w_to_nxt;
            // Pulse is high exactly while the FSM sits in SEND.
            r_tx_send <= (w_state_nxt == S_SEND);
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_tx_send    = r_tx_send;
    assign o_tx_data    = r_tx_data;
    assign o_fifo_count = r_count;
    assign o_fifo_empty = r_empty;
    assign o_fifo_full  = r_full;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_buffer
//   Scoreboard bench for uart_echo_buffer: every accepted byte is queued with
//   its expected stored value when driven, and popped/compared when the DUT
//   pulses tx_send. A small transmitter model raises tx_busy one cycle after
//   each send and holds it for 10 cycles (or stays low for timeout tests).
// -----------------------------------------------------------------------------
module tb_uart_echo_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       drain_en;
    logic       tx_busy;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_sends  = 0;
    int         cyc      = 0;
    int         last_send = 0;
    int         send_gap  = 0;
    bit         have_last = 1'b0;
    bit         busy_en   = 1'b0;
    bit         busy_pend = 1'b0;
    int         busy_left = 0;
    logic [7:0] sb [$];

    uart_echo_buffer #(.DEPTH(16), .DATA_W(8), .BUSY_TIMEOUT(15)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rx_data_valid (rx_valid),
        .i_rx_data       (rx_data),
        .i_drain_en      (drain_en),
        .i_tx_busy       (tx_busy),
        .o_tx_send       (tx_send),
        .o_tx_data       (tx_data),
        .o_fifo_count    (fifo_count),
        .o_fifo_empty    (fifo_empty),
        .o_fifo_full     (fifo_full),
        .o_overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Edge counter: value after edge k is k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] d);
`ifdef ECHO_UPPERCASE_EN
        if (d >= 8'h61 && d <= 8'h7A) return d - 8'h20;
        else return d;
`else
        return d;
`endif
    endfunction

    // Transmitter model: busy rises one cycle after a send, holds 10 cycles.
    always @(negedge clk) begin
        if (!busy_en) begin
            tx_busy   = 1'b0;
            busy_pend = 1'b0;
            busy_left = 0;
        end else if (tx_send) begin
            busy_pend = 1'b1;
        end else if (busy_pend) begin
            tx_busy   = 1'b1;
            busy_left = 10;
            busy_pend = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
    end

    // Scoreboard consumer: each send must match the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && tx_send) begin
            n_sends++;
            chk("busy_low_at_send", {31'd0, tx_busy}, 32'd0);
            if (have_last) begin
                send_gap = cyc + 1 - last_send;
                chk("send_spacing_ge4", {31'd0, (send_gap >= 4)}, 32'd1);
            end
            last_send = cyc + 1;
            have_last = 1'b1;
            chk("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, e});
            end
        end
    end

    // Drive one byte for one cycle, starting and ending at a negedge.
    task automatic push_byte(input logic [7:0] d, input bit accept);
        rx_data  = d;
        rx_valid = 1'b1;
        if (accept) sb.push_back(exp_byte(d));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_drained(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !tx_busy && fifo_empty) done = 1'b1;
        end
        chk(tag, {31'd0, done}, 32'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        sb.delete();
        busy_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        busy_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int push_cyc;
        bit seen;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        drain_en = 1'b0;
        busy_en  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_full",  {31'd0, fifo_full},  32'd0);
        chk("rst_ovf",   {31'd0, overflow},   32'd0);
        chk("rst_send",  {31'd0, tx_send},    32'd0);
        chk("rst_data",  {24'd0, tx_data},    32'd0);
        rst_n   = 1'b1;
        busy_en = 1'b1;
        @(negedge clk);

        // Single byte latency
        drain_en = 1'b1;
        s0 = n_sends;
        push_cyc = cyc + 1;
        push_byte(8'h41, 1'b1);
        wait_drained("t2_drain");
        chk("t2_latency", last_send - push_cyc, 32'd3);
        chk("t2_one_pulse", n_sends - s0, 32'd1);
        chk("t2_count", {27'd0, fifo_count}, 32'd0);

        // Hold then release
        drain_en = 1'b0;
        s0 = n_sends;
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i), 1'b1);
        @(negedge clk);
        chk("t3_count", {27'd0, fifo_count}, 32'd5);
        chk("t3_no_send", n_sends - s0, 32'd0);
        drain_en = 1'b1;
        wait_drained("t3_drain");
        chk("t3_sends", n_sends - s0, 32'd5);

        // Overflow
        drain_en = 1'b0;
        for (int i = 0; i < 18; i++) push_byte(8'hA0 + 8'(i), (i < 16));
        chk("t4_count", {27'd0, fifo_count}, 32'd16);
        chk("t4_full",  {31'd0, fifo_full},  32'd1);
        chk("t4_ovf",   {31'd0, overflow},   32'd1);
        drain_en = 1'b1;
        wait_drained("t4_drain");
        chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Simultaneous push/pop at full
        do_reset();
        drain_en = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i), 1'b1);
        chk("t5_full", {31'd0, fifo_full}, 32'd1);
        drain_en = 1'b1;
        @(negedge clk);
        push_byte(8'hD0, 1'b1);
        chk("t5_count", {27'd0, fifo_count}, 32'd16);
        chk("t5_ovf", {31'd0, overflow}, 32'd0);
        wait_drained("t5_drain");
        chk("t5_count_end", {27'd0, fifo_count}, 32'd0);

        // Timeout path: busy never rises
        busy_en = 1'b0;
        s0 = n_sends;
        push_byte(8'h55, 1'b1);
        push_byte(8'h56, 1'b1);
        wait_drained("t6_drain");
        chk("t6_sends", n_sends - s0, 32'd2);
        chk("t6_gap", send_gap, 32'd18);

        // Reset mid-frame
        busy_en = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i), 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (tx_busy) seen = 1'b1;
        end
        chk("t7_busy_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("t7_pre_count", {27'd0, fifo_count}, 32'd3);
        rst_n   = 1'b0;
        sb.delete();
        busy_en = 1'b0;
        @(negedge clk);
        chk("t7_count", {27'd0, fifo_count}, 32'd0);
        chk("t7_send",  {31'd0, tx_send},    32'd0);
        chk("t7_data",  {24'd0, tx_data},    32'd0);
        chk("t7_ovf",   {31'd0, overflow},   32'd0);
        chk("t7_empty", {31'd0, fifo_empty}, 32'd1);
        rst_n   = 1'b1;
        busy_en = 1'b1;
        @(negedge clk);

        // Case conversion on the write path (or verbatim when disabled)
        push_byte(8'h61, 1'b1);
        push_byte(8'h7B, 1'b1);
        push_byte(8'h5A, 1'b1);
        push_byte(8'h7A, 1'b1);
        wait_drained("t8_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
